// File: rtl/alu_seq.sv
// alu_seq: four-state sequencer (IDLE/READ/EXEC/WB) that issues operations
// to an external combinational ALU and writes results into a 4x16 register
// file. Optional flag outputs are enabled by defining ALU_SEQ_FLAGS_EN.
module alu_seq #(
    parameter int unsigned NREGS = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_result,
    output logic             wb_valid,
    output logic [1:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_n
`endif
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t state, state_next;

    logic [15:0]      instr_q;
    logic [WIDTH-1:0] regs [NREGS];

    logic [1:0] f_op, f_rd, f_rs1, f_rs2;
    logic [7:0] f_imm;
    logic       is_li;

    assign f_op  = instr_q[15:14];
    assign f_rd  = instr_q[13:12];
    assign f_rs1 = instr_q[11:10];
    assign f_rs2 = instr_q[9:8];
    assign f_imm = instr_q[7:0];
    assign is_li = (f_op == 2'b11);

    assign dbg_data = regs[dbg_addr];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake decode
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = READ;
            end
            READ:    state_next = is_li ? WB : EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, result capture and register write-back.
    // The ALU operand registers double as op_a/op_b and are loaded only for
    // ALU ops, so they keep their last driven value through loads and idle.
    // wb_data is the result register; it is written on entry to WB so the
    // pulse and the data appear together in the WB cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            alu_op   <= '0;
            alu_in1  <= '0;
            alu_in2  <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) instr_q <= instr;
                end
                READ: begin
                    if (is_li) begin
                        wb_valid <= 1'b1;
                        wb_addr  <= f_rd;
                        wb_data  <= WIDTH'(f_imm);
                    end else begin
                        alu_op  <= f_op;
                        alu_in1 <= regs[f_rs1];
                        alu_in2 <= regs[f_rs2];
                    end
                end
                EXEC: begin
                    wb_valid <= 1'b1;
                    wb_addr  <= f_rd;
                    wb_data  <= alu_result;
                end
                WB: begin
                    regs[wb_addr] <= wb_data;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    // Zero/negative flags, updated on write-back of ALU ops only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (state == WB && !is_li) begin
            flag_z <= (wb_data == '0);
            flag_n <= wb_data[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: models the external ALU, keeps a
// reference register file and a write-back scoreboard, and checks data,
// latency, handshake and ALU operand stability.
module tb_alu_seq;

    localparam logic [1:0] OP_ADD = 2'b00, OP_XOR = 2'b01, OP_SUB = 2'b10, OP_LI = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [1:0]  alu_op;
    logic [15:0] alu_in1, alu_in2, alu_result;
    logic        wb_valid;
    logic [1:0]  wb_addr;
    logic [15:0] wb_data;
    logic [1:0]  dbg_addr;
    logic [15:0] dbg_data;
`ifdef ALU_SEQ_FLAGS_EN
    logic        flag_z, flag_n;
    logic        exp_z = 1'b0, exp_n = 1'b0;
`endif

    alu_seq #(.NREGS(4), .WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_op(alu_op), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .alu_result(alu_result), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .wb_data(wb_data), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
`ifdef ALU_SEQ_FLAGS_EN
        , .flag_z(flag_z), .flag_n(flag_n)
`endif
    );

    always #5 clk = ~clk;

    // External ALU
    always_comb begin
        case (alu_op)
            2'b00:   alu_result = alu_in1 + alu_in2;
            2'b01:   alu_result = alu_in1 ^ alu_in2;
            2'b10:   alu_result = alu_in1 - alu_in2;
            default: alu_result = 16'h0000;
        endcase
    end

    typedef struct {
        logic [1:0]  addr;
        logic [15:0] data;
        int          acc;
        int          lat;
        bit          alu;
    } sb_t;

    sb_t         sb[$];
    int          acc_q[$];
    logic [15:0] ref_r [4];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [1:0]  exp_op = '0, pend_op;
    logic [15:0] exp_a = '0, exp_b = '0, pend_a, pend_b;
    int          pend_cyc;
    bit          pend_valid = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: scoreboard, latency, handshake, operand stability, flags
    always @(negedge clk) begin
        if (rst_n) begin
            if (pend_valid && cyc == pend_cyc) begin
                exp_op = pend_op; exp_a = pend_a; exp_b = pend_b;
                pend_valid = 0;
            end
            check("alu_op", 32'(alu_op), 32'(exp_op));
            check("alu_in1", 32'(alu_in1), 32'(exp_a));
            check("alu_in2", 32'(alu_in2), 32'(exp_b));
            check("instr_ready", 32'(instr_ready), 32'(sb.size() == 0));
`ifdef ALU_SEQ_FLAGS_EN
            check("flag_z", 32'(flag_z), 32'(exp_z));
            check("flag_n", 32'(flag_n), 32'(exp_n));
`endif
            if (wb_valid) begin
                if (sb.size() == 0) begin
                    check("wb_unexpected", 32'(wb_valid), 32'(0));
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("wb_addr", 32'(wb_addr), 32'(e.addr));
                    check("wb_data", 32'(wb_data), 32'(e.data));
                    check("wb_latency", 32'(cyc - e.acc), 32'(e.lat));
`ifdef ALU_SEQ_FLAGS_EN
                    if (e.alu) begin
                        exp_z = (e.data == 16'h0000);
                        exp_n = e.data[15];
                    end
`endif
                end
            end
            if (instr_valid && instr_ready) begin
                sb_t e;
                logic [1:0]  op, rd, rs1, rs2;
                logic [15:0] a, b, v;
                op = instr[15:14]; rd = instr[13:12];
                rs1 = instr[11:10]; rs2 = instr[9:8];
                a = ref_r[rs1]; b = ref_r[rs2];
                case (op)
                    OP_ADD:  v = a + b;
                    OP_XOR:  v = a ^ b;
                    OP_SUB:  v = a - b;
                    default: v = {8'h00, instr[7:0]};
                endcase
                ref_r[rd] = v;
                e.addr = rd; e.data = v; e.acc = cyc;
                e.lat = (op == OP_LI) ? 2 : 3;
                e.alu = (op != OP_LI);
                sb.push_back(e);
                acc_q.push_back(cyc);
                if (op != OP_LI) begin
                    pend_valid = 1; pend_cyc = cyc + 2;
                    pend_op = op; pend_a = a; pend_b = b;
                end
            end
        end
    end

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < 4; i++) ref_r[i] = 16'h0000;
        exp_op = '0; exp_a = '0; exp_b = '0; pend_valid = 0;
`ifdef ALU_SEQ_FLAGS_EN
        exp_z = 1'b0; exp_n = 1'b0;
`endif
    endtask

    // Present one instruction and wait for its acceptance; optionally
    // scramble instr/instr_valid while the sequencer is busy.
    task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] imm, input bit hold, input bit junk);
        bit done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (instr_ready) begin
                instr = {op, rd, rs1, rs2, imm};
                instr_valid = 1'b1;
                @(posedge clk); #1;
                done = 1;
            end else begin
                if (junk) begin
                    instr = 16'($urandom);
                    instr_valid = 1'($urandom_range(0, 1));
                end
                @(posedge clk); #1;
            end
        end
        if (!done) check("accept_timeout", 32'(instr_ready), 32'(1));
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done = 0;
        instr_valid = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (sb.size() == 0 && instr_ready) done = 1;
            else begin @(posedge clk); #1; end
        end
        if (!done) check("done_timeout", 32'(sb.size()), 32'(0));
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [15:0] v);
        dbg_addr = a;
        @(posedge clk); #1;
        check(tag, 32'(dbg_data), 32'(v));
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_op", 32'(alu_op), 32'(0));
        check("rst_alu_in1", 32'(alu_in1), 32'(0));
        check("rst_wb_valid", 32'(wb_valid), 32'(0));
        check("rst_wb_addr", 32'(wb_addr), 32'(0));
        check("rst_wb_data", 32'(wb_data), 32'(0));
        check("rst_ready", 32'(instr_ready), 32'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-EXEC aborts the add; registers cleared
        issue(OP_LI, 2'd0, 2'd0, 2'd0, 8'h55, 0, 0);
        wait_done();
        issue(OP_ADD, 2'd1, 2'd0, 2'd0, 8'h00, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_ready", 32'(instr_ready), 32'(1));
        for (int i = 0; i < 4; i++) chk_reg("abort_reg", 2'(i), 16'h0000);
        issue(OP_LI, 2'd3, 2'd0, 2'd0, 8'h0F, 0, 0);
        wait_done();
        chk_reg("li_r3", 2'd3, 16'h000F);

        // Simple add
        issue(OP_LI, 2'd0, 2'd0, 2'd0, 8'h12, 0, 0);
        wait_done();
        issue(OP_LI, 2'd1, 2'd0, 2'd0, 8'h34, 0, 0);
        wait_done();
        issue(OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00, 0, 0);
        wait_done();
        chk_reg("add_r2", 2'd2, 16'h0046);

        // Wrap-around and borrow
        issue(OP_LI, 2'd0, 2'd0, 2'd0, 8'hFF, 0, 0);
        wait_done();
        for (int i = 0; i < 8; i++) begin
            issue(OP_ADD, 2'd0, 2'd0, 2'd0, 8'h00, 0, 0);
            wait_done();
        end
        chk_reg("wrap_r0", 2'd0, 16'hFF00);
        issue(OP_LI, 2'd1, 2'd0, 2'd0, 8'h01, 0, 0);
        wait_done();
        issue(OP_SUB, 2'd2, 2'd1, 2'd0, 8'h00, 0, 0);
        wait_done();
        chk_reg("sub_r2", 2'd2, 16'h0101);

        // XOR with full aliasing, then a negative sub
        issue(OP_LI, 2'd1, 2'd0, 2'd0, 8'hAA, 0, 0);
        wait_done();
        issue(OP_XOR, 2'd1, 2'd1, 2'd1, 8'h00, 0, 0);
        wait_done();
        chk_reg("xor_r1", 2'd1, 16'h0000);
`ifdef ALU_SEQ_FLAGS_EN
        check("xor_flag_z", 32'(flag_z), 32'(1));
        check("xor_flag_n", 32'(flag_n), 32'(0));
`endif
        issue(OP_LI, 2'd3, 2'd0, 2'd0, 8'h01, 0, 0);
        wait_done();
        issue(OP_SUB, 2'd3, 2'd1, 2'd3, 8'h00, 0, 0);
        wait_done();
        chk_reg("neg_r3", 2'd3, 16'hFFFF);
`ifdef ALU_SEQ_FLAGS_EN
        check("neg_flag_z", 32'(flag_z), 32'(0));
        check("neg_flag_n", 32'(flag_n), 32'(1));
`endif

        // Back-to-back with instr_valid held high
        acc_q.delete();
        issue(OP_ADD, 2'd0, 2'd3, 2'd2, 8'h00, 1, 0);
        issue(OP_XOR, 2'd1, 2'd0, 2'd3, 8'h00, 1, 0);
        issue(OP_SUB, 2'd2, 2'd1, 2'd0, 8'h00, 1, 0);
        wait_done();
        if (acc_q.size() == 3) begin
            check("b2b_gap1", 32'(acc_q[1] - acc_q[0]), 32'(4));
            check("b2b_gap2", 32'(acc_q[2] - acc_q[1]), 32'(4));
        end else begin
            check("b2b_count", 32'(acc_q.size()), 32'(3));
        end

        // Random instr activity while busy must be ignored
        issue(OP_ADD, 2'd3, 2'd0, 2'd1, 8'h00, 0, 1);
        issue(OP_LI,  2'd2, 2'd0, 2'd0, 8'hC3, 0, 1);
        issue(OP_SUB, 2'd0, 2'd2, 2'd3, 8'h00, 0, 1);
        issue(OP_XOR, 2'd1, 2'd0, 2'd2, 8'h00, 0, 1);
        issue(OP_LI,  2'd3, 2'd0, 2'd0, 8'h7E, 0, 1);
        wait_done();
        for (int i = 0; i < 4; i++) chk_reg("final_reg", 2'(i), ref_r[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
